// File: rtl/ab_input_pkg.sv
// Shared types and defaults for the A/B input conditioner: debounce FSM state
// encoding and default synchroniser/debounce parameters.
package ab_input_pkg;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
    localparam int unsigned CNT_W_DEF           = 16;

    // Bit 1 of the encoding is the debounced level.
    typedef enum logic [1:0] {
        StLow      = 2'b00,
        StRiseWait = 2'b01,
        StHigh     = 2'b11,
        StFallWait = 2'b10
    } state_e;

endpackage

// File: rtl/debounce_channel.sv
// One conditioner channel: synchroniser chain, debounce counter and FSM.
// Optional rise pulse output under AB_INPUT_CONDITIONER_RISE_PULSE_EN.
module debounce_channel
    import ab_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
`ifdef AB_INPUT_CONDITIONER_RISE_PULSE_EN
    ,
    output logic rise_o
`endif
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W) ||
        SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_param
        $error("debounce_channel: illegal SYNC_STAGES/DEBOUNCE_CYCLES/CNT_W");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   enter_high;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A single agreeing sample suffices when DEBOUNCE_CYCLES is 1.
    always_comb begin
        enter_high = 1'b0;
        if (s) begin
            if (state_q == StLow && DEBOUNCE_CYCLES == 1) begin
                enter_high = 1'b1;
            end else if (state_q == StRiseWait && cnt_q == CntLast) begin
                enter_high = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StLow;
            cnt_q   <= '0;
`ifdef AB_INPUT_CONDITIONER_RISE_PULSE_EN
            rise_o  <= 1'b0;
`endif
        end else begin
`ifdef AB_INPUT_CONDITIONER_RISE_PULSE_EN
            rise_o <= enter_high;
`endif
            unique case (state_q)
                StLow: begin
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= StHigh;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StRiseWait;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                StRiseWait: begin
                    if (!s) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                    end else if (enter_high) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StHigh: begin
                    if (!s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= StLow;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StFallWait;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                StFallWait: begin
                    if (s) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StLow;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o = state_q[1];

endmodule

// File: rtl/ab_input_conditioner.sv
// Synchronises and debounces the raw A/B button levels for the sequential lab
// circuit. Define AB_INPUT_CONDITIONER_RISE_PULSE_EN for a_rise/b_rise pulses.
module ab_input_conditioner
    import ab_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b
`ifdef AB_INPUT_CONDITIONER_RISE_PULSE_EN
    ,
    output logic a_rise,
    output logic b_rise
`endif
);

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_a (
        .clk_i  (clk),
        .rst_ni (rst),
        .raw_i  (a_raw),
        .level_o(a)
`ifdef AB_INPUT_CONDITIONER_RISE_PULSE_EN
        ,
        .rise_o (a_rise)
`endif
    );

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_chan_b (
        .clk_i  (clk),
        .rst_ni (rst),
        .raw_i  (b_raw),
        .level_o(b)
`ifdef AB_INPUT_CONDITIONER_RISE_PULSE_EN
        ,
        .rise_o (b_rise)
`endif
    );

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Scoreboard bench for ab_input_conditioner: a run-length reference model pushes
// expected {a,b,a_rise,b_rise} each edge; the monitor pops and compares.
module tb_ab_input_conditioner;

    localparam int unsigned SyncStages = 2;
    localparam int unsigned DebCycles  = 4;
    localparam int unsigned CntW       = 4;

    logic clk = 1'b0;
    logic rst;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic a_rise;
    logic b_rise;

`ifdef AB_INPUT_CONDITIONER_RISE_PULSE_EN
    logic a1;
    logic b1;
    logic a1_rise;
    logic b1_rise;
    int   rise1_a_cnt = 0;
    int   rise1_b_cnt = 0;

    ab_input_conditioner #(
        .SYNC_STAGES    (SyncStages),
        .DEBOUNCE_CYCLES(DebCycles),
        .CNT_W          (CntW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a     (a),
        .b     (b),
        .a_rise(a_rise),
        .b_rise(b_rise)
    );

    ab_input_conditioner #(
        .SYNC_STAGES    (SyncStages),
        .DEBOUNCE_CYCLES(1),
        .CNT_W          (CntW)
    ) dut1 (
        .clk   (clk),
        .rst   (rst),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a     (a1),
        .b     (b1),
        .a_rise(a1_rise),
        .b_rise(b1_rise)
    );
`else
    ab_input_conditioner #(
        .SYNC_STAGES    (SyncStages),
        .DEBOUNCE_CYCLES(DebCycles),
        .CNT_W          (CntW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .a_raw(a_raw),
        .b_raw(b_raw),
        .a    (a),
        .b    (b)
    );
    assign a_rise = 1'b0;
    assign b_rise = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: output follows the synchronised sample once that sample
    // has disagreed with the output for DebCycles consecutive edges.
    logic [SyncStages-1:0] msync_a = '0;
    logic [SyncStages-1:0] msync_b = '0;
    logic                  mout_a  = 1'b0;
    logic                  mout_b  = 1'b0;
    int                    mrun_a  = 0;
    int                    mrun_b  = 0;
    logic [3:0]            exp_q[$];

    task automatic model_ch(input logic rs, input logic raw,
                            input logic [SyncStages-1:0] sync_in, input logic out_in,
                            input int run_in, output logic [SyncStages-1:0] sync_out,
                            output logic out_out, output int run_out, output logic rise);
        logic smp;
        rise = 1'b0;
        if (!rs) begin
            sync_out = '0;
            out_out  = 1'b0;
            run_out  = 0;
        end else begin
            smp      = sync_in[SyncStages-1];
            sync_out = {sync_in[SyncStages-2:0], raw};
            out_out  = out_in;
            run_out  = 0;
            if (smp != out_in) begin
                run_out = run_in + 1;
                if (run_out == int'(DebCycles)) begin
                    out_out = smp;
                    run_out = 0;
                    rise    = smp;
                end
            end
        end
    endtask

    task automatic step(input logic rs, input logic ar, input logic br, input string tag);
        logic       ra;
        logic       rb;
        logic [3:0] got;
        logic [3:0] exp;
        @(negedge clk);
        rst   = rs;
        a_raw = ar;
        b_raw = br;
        @(posedge clk);
        model_ch(rs, ar, msync_a, mout_a, mrun_a, msync_a, mout_a, mrun_a, ra);
        model_ch(rs, br, msync_b, mout_b, mrun_b, msync_b, mout_b, mrun_b, rb);
`ifdef AB_INPUT_CONDITIONER_RISE_PULSE_EN
        exp_q.push_back({mout_a, mout_b, ra, rb});
`else
        exp_q.push_back({mout_a, mout_b, 2'b00});
`endif
        #1;
        got = {a, b, a_rise, b_rise};
        exp = exp_q.pop_front();
        check(tag, int'(got), int'(exp));
`ifdef AB_INPUT_CONDITIONER_RISE_PULSE_EN
        if (a1_rise) rise1_a_cnt++;
        if (b1_rise) rise1_b_cnt++;
`endif
    endtask

    logic [15:0] bounce_pat;

    initial begin
        rst   = 1'b0;
        a_raw = 1'b0;
        b_raw = 1'b0;

        // Reset held with both raw inputs high.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, "reset_hold");
            check("reset_a", int'(a), 0);
            check("reset_b", int'(b), 0);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b1, "post_reset");
            if (i == 4) check("post_reset_a_e4", int'(a), 0);
            if (i == 5) check("post_reset_a_e5", int'(a), 1);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, "settle_low");

        // Clean rising edge on A only.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, "clean_rise");
            if (i == 4) check("clean_a_e4", int'(a), 0);
            if (i == 5) check("clean_a_e5", int'(a), 1);
        end
        check("clean_b_quiet", int'(b), 0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, "settle_low");

        // Bounce on A: 1,0,1,0 then low, then held high from edge 10.
        bounce_pat = 16'b1111_1100_0000_0101;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, bounce_pat[i], 1'b0, "bounce");
            if (i == 14) check("bounce_a_e14", int'(a), 0);
            if (i == 15) check("bounce_a_e15", int'(a), 1);
        end

        // Both high, then a simultaneous drop.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, "both_high");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, "both_fall");
            if (i == 4) check("fall_ab_e4", int'({a, b}), 3);
            if (i == 5) check("fall_ab_e5", int'({a, b}), 0);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "settle_low");

        // Reset in the middle of a rising count.
        for (int i = 0; i < 11; i++) begin
            step((i == 3) ? 1'b0 : 1'b1, 1'b1, 1'b0, "reset_mid");
            if (i == 8) check("midrst_a_e8", int'(a), 0);
            if (i == 9) check("midrst_a_e9", int'(a), 1);
        end

`ifdef AB_INPUT_CONDITIONER_RISE_PULSE_EN
        // DEBOUNCE_CYCLES=1 instance: one rise pulse per channel, none on fall.
        step(1'b0, 1'b0, 1'b0, "rise1_reset");
        rise1_a_cnt = 0;
        rise1_b_cnt = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, "rise1_up");
        check("rise1_a_level", int'(a1), 1);
        check("rise1_a_pulses", rise1_a_cnt, 1);
        check("rise1_b_pulses", rise1_b_cnt, 1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, "rise1_down");
        check("rise1_b_level", int'(b1), 0);
        check("rise1_a_no_fall_pulse", rise1_a_cnt, 1);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
